// File: rtl/ds_slot_scheduler_pkg.sv
// Shared types and helpers for the symbol-synchronous slot scheduler.
package ds_mux_pkg;
  typedef enum logic [1:0] {SEL_DS1, SEL_DS2, SEL_DS3, SEL_NONE} sel_t;
  typedef enum logic {IDLE, RUN} state_t;

  function automatic int cps(input int clk_f, input int symbol_clk_f);
    return clk_f / symbol_clk_f;
  endfunction

  function automatic logic [1:0] popcnt3(input logic [2:0] r);
    return {1'b0, r[0]} + {1'b0, r[1]} + {1'b0, r[2]};
  endfunction

  // Granted stream indices in service order, starting at the first granted index >= ptr.
  function automatic logic [2:0][1:0] rr_order(input logic [2:0] r, input logic [1:0] ptr);
    logic [2:0][1:0] o;
    logic [1:0]      n;
    logic [1:0]      idx;
    o = {3{2'd3}};
    n = '0;
    for (int i = 0; i < 3; i++) begin
      idx = 2'((int'(ptr) + i) % 3);
      if (r[idx]) begin
        o[n] = idx;
        n    = n + 2'd1;
      end
    end
    return o;
  endfunction
endpackage

// File: rtl/ds_slot_scheduler_if.sv
// Stream inputs, symbol clock and multiplexed outputs of the slot scheduler.
interface ds_slot_scheduler_if import ds_mux_pkg::*; #(parameter int ds_width = 8);
  logic                symbol_clk;
  logic [2:0]          req;
  logic [ds_width-1:0] ds1, ds2, ds3;
  logic [1:0]          mode;
  logic [2:0]          grant;
  sel_t                sel;
  logic                slot_start;
  logic [ds_width-1:0] mux_data;
  logic                mux_valid;
  logic                err_sym_len;

  modport master (output symbol_clk, req, ds1, ds2, ds3,
                  input  mode, grant, sel, slot_start, mux_data, mux_valid, err_sym_len);
  modport slave  (input  symbol_clk, req, ds1, ds2, ds3,
                  output mode, grant, sel, slot_start, mux_data, mux_valid, err_sym_len);
endinterface

// File: rtl/ds_slot_timer.sv
// Symbol cycle counter and slot boundary decode; outputs describe the next cycle.
module ds_slot_timer import ds_mux_pkg::*; #(
  parameter int CPS = 100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic [1:0]             mode,
  output logic [$clog2(CPS)-1:0] cnt,
  output logic [1:0]             slot_idx,
  output logic                   slot_start
);
  localparam int              CW   = $clog2(CPS);
  localparam logic [CW-1:0]   LAST = CW'(CPS - 1);
  localparam logic [CW+1:0]   B2   = (CW+2)'(CPS / 2);
  localparam logic [CW+1:0]   B3A  = (CW+2)'(CPS / 3);
  localparam logic [CW+1:0]   B3B  = (CW+2)'(2 * (CPS / 3));

  logic [CW-1:0] cnt_nxt;
  logic [CW+1:0] c;
  logic          bnd;

  always_comb begin
    cnt_nxt = cnt;
    if (clr)                    cnt_nxt = '0;
    else if (en && cnt != LAST) cnt_nxt = cnt + CW'(1);
    c        = {2'b00, cnt_nxt};
    slot_idx = 2'd0;
    bnd      = 1'b0;
    // The last slot runs to the end of the symbol, absorbing the remainder.
    case (mode)
      2'd2: begin
        if (c >= B2) slot_idx = 2'd1;
        bnd = (c == B2);
      end
      2'd3: begin
        if (c >= B3B)      slot_idx = 2'd2;
        else if (c >= B3A) slot_idx = 2'd1;
        bnd = (c == B3A) || (c == B3B);
      end
      default: ;
    endcase
    slot_start = clr ? (mode != 2'd0) : (en && bnd && (cnt_nxt != cnt));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= cnt_nxt;
  end
endmodule

// File: rtl/ds_slot_scheduler.sv
// TDM slot scheduler: snapshots requests at each symbol edge and grants equal slots round-robin.
module ds_slot_scheduler import ds_mux_pkg::*; #(
  parameter int clk_f        = 100_000_000,
  parameter int symbol_clk_f = 1_000_000,
  parameter int ds_width     = 8
) (
  input logic               clk,
  input logic               rst,
  ds_slot_scheduler_if.slave bus
);
  localparam int            CPS  = cps(clk_f, symbol_clk_f);
  localparam int            CW   = $clog2(CPS);
  localparam logic [CW-1:0] LAST = CW'(CPS - 1);

  state_t              state;
  logic                sym_q, sym_edge, run;
  logic [1:0]          mode_q, new_mode, mode_eff, rr_ptr;
  logic [2:0]          grant_q;
  logic [2:0][1:0]     own_q, new_own, own_eff;
  logic [CW-1:0]       cnt;
  logic [1:0]          slot_idx;
  logic                ss_nxt, ss_q, valid_q, err_q;
  sel_t                sel_q, sel_nxt;
  logic [ds_width-1:0] data_q, data_nxt;

  assign sym_edge = bus.symbol_clk & ~sym_q;
  assign run      = (state == RUN);
  assign new_mode = popcnt3(bus.req);
  assign new_own  = rr_order(bus.req, rr_ptr);
  // A new symbol takes effect in the same cycle it is detected.
  assign mode_eff = sym_edge ? new_mode : mode_q;
  assign own_eff  = sym_edge ? new_own  : own_q;

  ds_slot_timer #(.CPS(CPS)) u_timer (
    .clk(clk), .rst(rst), .clr(sym_edge), .en(run), .mode(mode_eff),
    .cnt(cnt), .slot_idx(slot_idx), .slot_start(ss_nxt)
  );

  always_comb begin
    sel_nxt = (mode_eff == 2'd0) ? SEL_NONE : sel_t'(own_eff[slot_idx]);
    case (sel_nxt)
      SEL_DS1: data_nxt = bus.ds1;
      SEL_DS2: data_nxt = bus.ds2;
      SEL_DS3: data_nxt = bus.ds3;
      default: data_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      sym_q   <= 1'b0;
      mode_q  <= '0;
      grant_q <= '0;
      own_q   <= '1;
      rr_ptr  <= '0;
      sel_q   <= SEL_NONE;
      ss_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sym_q <= bus.symbol_clk;
      if (sym_edge) begin
        state   <= RUN;
        grant_q <= bus.req;
        mode_q  <= new_mode;
        own_q   <= new_own;
        if (new_mode != 2'd0) rr_ptr <= (new_own[0] == 2'd2) ? 2'd0 : new_own[0] + 2'd1;
      end
      // Early edge, or the counter sitting saturated with no edge arriving.
      if (run && (sym_edge ? (cnt != LAST) : (cnt == LAST))) err_q <= 1'b1;
      if (sym_edge || run) begin
        sel_q   <= sel_nxt;
        ss_q    <= ss_nxt;
        data_q  <= data_nxt;
        valid_q <= (sel_nxt != SEL_NONE);
      end
    end
  end

  assign bus.mode        = mode_q;
  assign bus.grant       = grant_q;
  assign bus.sel         = sel_q;
  assign bus.slot_start  = ss_q;
  assign bus.mux_data    = data_q;
  assign bus.mux_valid   = valid_q;
  assign bus.err_sym_len = err_q;
endmodule

// File: tb/tb_ds_slot_scheduler.sv
// Directed bench for ds_slot_scheduler: table of symbols plus hand-written timing corner cases.
module tb_ds_slot_scheduler;
  import ds_mux_pkg::*;

  logic clk = 1'b0;
  logic rst;
  ds_slot_scheduler_if #(.ds_width(8)) bus();
  ds_slot_scheduler #(.clk_f(100_000_000), .symbol_clk_f(1_000_000), .ds_width(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req;
    logic [1:0] mode;
    logic [1:0] o0, o1, o2;
  } vec_t;

  vec_t       vt [9];
  int         total = 0;
  int         bad   = 0;
  logic [1:0] obs_sel [0:255];
  logic       obs_ss  [0:255];
  logic       obs_mv  [0:255];
  logic       obs_err [0:255];
  logic [7:0] obs_md  [0:255];
  logic [7:0] pd      [0:255][0:2];

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h exp=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic tick(input int i);
    pd[i][0] = bus.ds1; pd[i][1] = bus.ds2; pd[i][2] = bus.ds3;
    @(posedge clk); #1;
    obs_sel[i] = bus.sel;       obs_ss[i]  = bus.slot_start;
    obs_mv[i]  = bus.mux_valid; obs_md[i]  = bus.mux_data;
    obs_err[i] = bus.err_sym_len;
    bus.ds1 = 8'($urandom); bus.ds2 = 8'($urandom); bus.ds3 = 8'($urandom);
  endtask

  task automatic run_sym(input logic [2:0] r, input int len, input int chg_at, input logic [2:0] chg_r);
    bus.req = r;
    bus.symbol_clk = 1'b1;
    for (int i = 0; i < len; i++) begin
      tick(i);
      if (i == 0) bus.symbol_clk = 1'b0;
      if (i == chg_at) bus.req = chg_r;
    end
  endtask

  task automatic chk_sym(input string nm, input int id, input logic [2:0] g, input logic [1:0] m,
                         input logic [1:0] o0, input logic [1:0] o1, input logic [1:0] o2, input int len);
    logic [1:0] own [3];
    int L, c, k;
    logic [1:0] es;
    logic ess;
    logic [7:0] emd;
    own[0] = o0; own[1] = o1; own[2] = o2;
    check({nm, "_mode"}, id, 32'(bus.mode), 32'(m));
    check({nm, "_grant"}, id, 32'(bus.grant), 32'(g));
    L = (m == 2'd0) ? 1 : 100 / int'(m);
    for (int i = 0; i < len; i++) begin
      c = (i > 99) ? 99 : i;
      k = c / L;
      if (k > int'(m) - 1) k = int'(m) - 1;
      if (m == 2'd0) begin
        es = 2'd3; ess = 1'b0;
      end else begin
        es  = own[k];
        ess = (i < 100) && (i % L == 0) && (i / L < int'(m));
      end
      emd = (es == 2'd3) ? 8'h00 : pd[i][es];
      check({nm, "_slot"}, id * 1000 + i,
            32'({obs_sel[i], obs_ss[i], obs_mv[i], obs_md[i]}),
            32'({es, ess, (es != 2'd3), emd}));
    end
  endtask

  task automatic chk_rst(input string nm);
    check({nm, "_mode"},  0, 32'(bus.mode), 0);
    check({nm, "_grant"}, 0, 32'(bus.grant), 0);
    check({nm, "_sel"},   0, 32'(bus.sel), 3);
    check({nm, "_ss"},    0, 32'(bus.slot_start), 0);
    check({nm, "_data"},  0, 32'(bus.mux_data), 0);
    check({nm, "_valid"}, 0, 32'(bus.mux_valid), 0);
    check({nm, "_err"},   0, 32'(bus.err_sym_len), 0);
  endtask

  task automatic idle_run(input string nm);
    bus.req = 3'b111;
    for (int i = 0; i < 5; i++) begin
      tick(i);
      check({nm, "_sel"},  i, 32'(obs_sel[i]), 3);
      check({nm, "_ss"},   i, 32'(obs_ss[i]), 0);
      check({nm, "_mode"}, i, 32'(bus.mode), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // req, mode, service order (3 = unused)
    vt[0] = '{3'b111, 2'd3, 2'd0, 2'd1, 2'd2};
    vt[1] = '{3'b111, 2'd3, 2'd1, 2'd2, 2'd0};
    vt[2] = '{3'b101, 2'd2, 2'd2, 2'd0, 2'd3};
    vt[3] = '{3'b101, 2'd2, 2'd0, 2'd2, 2'd3};
    vt[4] = '{3'b101, 2'd2, 2'd2, 2'd0, 2'd3};
    vt[5] = '{3'b000, 2'd0, 2'd3, 2'd3, 2'd3};
    vt[6] = '{3'b011, 2'd2, 2'd0, 2'd1, 2'd3};
    vt[7] = '{3'b100, 2'd1, 2'd2, 2'd3, 2'd3};
    vt[8] = '{3'b010, 2'd1, 2'd1, 2'd3, 2'd3};

    rst = 1'b0;
    bus.symbol_clk = 1'b0;
    bus.req = '0;
    bus.ds1 = 8'h11; bus.ds2 = 8'h22; bus.ds3 = 8'h33;
    repeat (2) @(posedge clk);
    #1;
    chk_rst("reset");
    rst = 1'b1;
    idle_run("idle");

    for (int v = 0; v < 9; v++) begin
      run_sym(vt[v].req, 100, -1, 3'b000);
      chk_sym("vec", v, vt[v].req, vt[v].mode, vt[v].o0, vt[v].o1, vt[v].o2, 100);
    end

    // Request change mid-symbol is ignored until the next edge.
    run_sym(3'b111, 100, 40, 3'b010);
    chk_sym("req_chg", 0, 3'b111, 2'd3, 2'd2, 2'd0, 2'd1, 100);
    run_sym(3'b010, 100, -1, 3'b000);
    chk_sym("req_chg", 1, 3'b010, 2'd1, 2'd1, 2'd3, 2'd3, 100);
    check("err_normal", 0, 32'(bus.err_sym_len), 0);

    // Early edge at cnt=60, then a long symbol holding the last owner.
    run_sym(3'b111, 61, -1, 3'b000);
    chk_sym("early", 0, 3'b111, 2'd3, 2'd2, 2'd0, 2'd1, 61);
    check("err_legal_edge", 0, 32'(obs_err[0]), 0);
    run_sym(3'b111, 131, -1, 3'b000);
    chk_sym("late_hold", 1, 3'b111, 2'd3, 2'd0, 2'd1, 2'd2, 131);
    check("err_early", 0, 32'(obs_err[0]), 1);

    // Mid-symbol reset, then idle until the next edge.
    run_sym(3'b111, 51, -1, 3'b000);
    chk_sym("pre_rst", 0, 3'b111, 2'd3, 2'd1, 2'd2, 2'd0, 51);
    rst = 1'b0;
    #1;
    chk_rst("mid_rst");
    @(posedge clk); #1;
    rst = 1'b1;
    idle_run("post_rst_idle");

    // Round-robin restarts at stream 0; missing edge flags a late symbol.
    run_sym(3'b111, 102, -1, 3'b000);
    chk_sym("after_rst", 0, 3'b111, 2'd3, 2'd0, 2'd1, 2'd2, 102);
    check("err_not_yet", 0, 32'(obs_err[99]), 0);
    check("err_late", 0, 32'(obs_err[101]), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
